// File: rtl/transform_dec_pkg.sv
// transform_dec_pkg: shared types, 2-of-5 code tables, range bounds and BCD helpers for transform_decoder
package transform_dec_pkg;

    typedef enum logic [1:0] {FMT_XS3, FMT_74210, FMT_63210, FMT_BIN} fmt_t;
    typedef enum logic [2:0] {IDLE, DIGIT, BIN, CHECK, OUT} state_t;
    typedef enum logic [1:0] {ERR_OK, ERR_CODE, ERR_RANGE, ERR_UNUSED} err_t;

    // Entry d sits at bits [5*d +: 5]
    localparam logic [49:0] TBL_74210 = {5'b10100, 5'b10010, 5'b10001, 5'b01100, 5'b01010,
                                         5'b01001, 5'b00110, 5'b00101, 5'b00011, 5'b11000};
    localparam logic [49:0] TBL_63210 = {5'b11000, 5'b10100, 5'b10010, 5'b10001, 5'b01100,
                                         5'b01010, 5'b01001, 5'b00101, 5'b00011, 5'b00110};

    localparam logic [9:0] MAX_XS3   = 10'd99;
    localparam logic [9:0] MAX_74210 = 10'd449;
    localparam logic [9:0] MAX_63210 = 10'd899;
    localparam logic [9:0] MAX_BIN   = 10'd999;

    function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++)
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [9:0] bcd_value(input logic [11:0] b);
        return 10'(b[11:8]) * 10'd100 + 10'(b[7:4]) * 10'd10 + 10'(b[3:0]);
    endfunction

endpackage

// File: rtl/two_of_five_dec.sv
// two_of_five_dec: combinational 2-of-5 digit decoder for the 74210 or 63210 weight set
module two_of_five_dec
    import transform_dec_pkg::*;
(
    input  logic [4:0] code,
    input  logic       sel_63210,
    output logic [3:0] digit,
    output logic       valid
);

    logic [49:0] tbl;

    always_comb begin
        tbl = sel_63210 ? TBL_63210 : TBL_74210;
        digit = 4'd0;
        valid = 1'b0;
        for (int i = 0; i < 10; i++)
            if (code == tbl[i*5 +: 5]) begin
                digit = 4'(i);
                valid = 1'b1;
            end
    end

endmodule

// File: rtl/transform_decoder.sv
// transform_decoder: multi-cycle coded-word to 3-digit BCD decoder; TRANSFORM_DEC_RANGE_CHECK_EN enables the range check (err 2)
module transform_decoder
    import transform_dec_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] code_in,
    input  logic [1:0]  fmt_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] bcd_out,
    output logic [1:0]  err_code
);

    state_t      state, state_nx;
    fmt_t        fmt;
    err_t        err;
    logic [14:0] word;
    logic [1:0]  cnt;
    logic [3:0]  it;
    logic [11:0] bcd;
    logic [10:0] adj;
    logic [4:0]  code5;
    logic [3:0]  nib, dig, dig5;
    logic        dig_ok, ok5, in_range;

    assign in_ready  = state == IDLE;
    assign out_valid = state == OUT;
    assign bcd_out   = out_valid ? bcd : 12'd0;
    assign err_code  = out_valid ? err : ERR_OK;

    two_of_five_dec u_dec (
        .code      (code5),
        .sel_63210 (fmt == FMT_63210),
        .digit     (dig5),
        .valid     (ok5)
    );

    always_comb begin
        code5  = cnt == 2'd2 ? word[14:10] : cnt == 2'd1 ? word[9:5] : word[4:0];
        nib    = cnt == 2'd2 ? word[11:8] : cnt == 2'd1 ? word[7:4] : word[3:0];
        dig    = fmt == FMT_XS3 ? nib - 4'd3 : dig5;
        dig_ok = fmt == FMT_XS3 ? (nib >= 4'd3 && nib <= 4'd12) : ok5;
        adj    = 11'(dabble_adjust(bcd));
    end

`ifdef TRANSFORM_DEC_RANGE_CHECK_EN
    logic [9:0] val, lo, hi;

    always_comb begin
        val = bcd_value(bcd);
        lo = fmt == FMT_74210 ? MAX_XS3 + 10'd1 : fmt == FMT_63210 ? MAX_74210 + 10'd1 :
             fmt == FMT_BIN ? MAX_63210 + 10'd1 : 10'd0;
        hi = fmt == FMT_74210 ? MAX_74210 : fmt == FMT_63210 ? MAX_63210 :
             fmt == FMT_BIN ? MAX_BIN : MAX_XS3;
        in_range = val >= lo && val <= hi;
    end
`else
    assign in_range = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid) state_nx = fmt_in == 2'd3 ? BIN : DIGIT;
            DIGIT:   if (cnt == 2'd0) state_nx = CHECK;
            BIN:     if (it == 4'd9) state_nx = CHECK;
            CHECK:   state_nx = OUT;
            OUT:     if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    // Unused-bit and binary-overflow errors are known at accept; later errors only land if none is set yet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            fmt  <= FMT_XS3;
            err  <= ERR_OK;
            cnt  <= '0;
            it   <= '0;
            bcd  <= '0;
        end else if (state == IDLE && in_valid) begin
            word <= code_in;
            fmt  <= fmt_t'(fmt_in);
            cnt  <= 2'd2;
            it   <= 4'd0;
            bcd  <= '0;
            err  <= ((fmt_in == 2'd0 && code_in[14:12] != 3'd0) ||
                     (fmt_in == 2'd3 && code_in[14:10] != 5'd0)) ? ERR_UNUSED :
                    (fmt_in == 2'd3 && code_in[9:0] > MAX_BIN) ? ERR_CODE : ERR_OK;
        end else if (state == DIGIT) begin
            bcd <= cnt == 2'd2 ? {dig, bcd[7:0]} :
                   cnt == 2'd1 ? {bcd[11:8], dig, bcd[3:0]} : {bcd[11:4], dig};
            cnt <= cnt - 2'd1;
            if (!dig_ok && err == ERR_OK) err <= ERR_CODE;
        end else if (state == BIN) begin
            {bcd, word[9:0]} <= {adj, word[9:0], 1'b0};
            it <= it + 4'd1;
        end else if (state == CHECK) begin
            if (err == ERR_CODE || err == ERR_UNUSED) bcd <= '0;
            else if (err == ERR_OK && !in_range)      err <= ERR_RANGE;
        end
    end

endmodule

// File: tb/tb_transform_decoder.sv
// tb_transform_decoder: table-driven scoreboard bench for transform_decoder
module tb_transform_decoder;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [14:0] code_in = '0;
    logic [1:0]  fmt_in = '0;
    logic        in_ready, out_valid;
    logic [11:0] bcd_out;
    logic [1:0]  err_code;

    transform_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code_in   (code_in),
        .fmt_in    (fmt_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] code;
        logic [1:0]  fmt;
        logic [11:0] bcd;
        logic [1:0]  err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [11:0] bcd;
        logic [1:0]  err;
        int          lat;
    } exp_t;

`ifdef TRANSFORM_DEC_RANGE_CHECK_EN
    localparam logic [1:0] E_RNG = 2'd2;
`else
    localparam logic [1:0] E_RNG = 2'd0;
`endif

    vec_t vecs[16];
    exp_t sb[$];
    int   errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        in_valid = 1'b1;
        code_in  = v.code;
        fmt_in   = v.fmt;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back('{v.bcd, v.err, v.lat});
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic collect(input string name, input int lat);
        exp_t e;
        e = sb.pop_front();
        chk({name, " lat"}, lat, e.lat);
        chk({name, " bcd"}, bcd_out, e.bcd);
        chk({name, " err"}, err_code, e.err);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, " in_ready after"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        vecs[0]  = '{15'h037A, 2'd0, 12'h047, 2'd0, 4};
        vecs[1]  = '{15'h0CA6, 2'd1, 12'h123, 2'd0, 4};
        vecs[2]  = '{15'h48CC, 2'd2, 12'h705, 2'd0, 4};
        vecs[3]  = '{15'h03E7, 2'd3, 12'h999, 2'd0, 11};
        vecs[4]  = '{15'h03E8, 2'd3, 12'h000, 2'd1, 11};
        vecs[5]  = '{15'h0CA7, 2'd1, 12'h000, 2'd1, 4};
        vecs[6]  = '{15'h0433, 2'd0, 12'h100, E_RNG, 4};
        vecs[7]  = '{15'h1333, 2'd0, 12'h000, 2'd3, 4};
        vecs[8]  = '{15'h03CC, 2'd0, 12'h099, 2'd0, 4};
        vecs[9]  = '{15'h0384, 2'd3, 12'h900, 2'd0, 11};
        vecs[10] = '{15'h01F4, 2'd3, 12'h500, E_RNG, 11};
        vecs[11] = '{15'h0D33, 2'd0, 12'h000, 2'd1, 4};
        vecs[12] = '{15'h03A5, 2'd3, 12'h933, 2'd0, 11};
        vecs[13] = '{15'h2958, 2'd2, 12'h449, E_RNG, 4};
        vecs[14] = '{15'h2534, 2'd1, 12'h449, 2'd0, 4};
        vecs[15] = '{15'h0400, 2'd3, 12'h000, 2'd3, 11};

        #12;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset bcd", bcd_out, 0);
        chk("reset err", err_code, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            send(vecs[i]);
            wait_out(lat);
            collect($sformatf("vec%0d", i), lat);
        end

        send(vecs[1]);
        wait_out(lat);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            code_in  = 15'h037A;
            fmt_in   = 2'd0;
            @(posedge clk); #1;
            chk("hold out_valid", out_valid, 1);
            chk("hold bcd", bcd_out, 12'h123);
            chk("hold err", err_code, 0);
            chk("hold in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        collect("backpressure", lat);

        in_valid = 1'b1;
        code_in  = 15'h03E7;
        fmt_in   = 2'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset in_ready", in_ready, 1);
        chk("midreset out_valid", out_valid, 0);
        chk("midreset bcd", bcd_out, 0);
        chk("midreset err", err_code, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send(vecs[2]);
        wait_out(lat);
        collect("after reset", lat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
